device_hub: RTL

Parametrised N-channel input-device selector that replaces the fixed 4-way switch-driven output mux at the top level. It watches every device's payload for activity. It routes one channel to the LED/seven-segment path, either under manual switch control or automatically to the most recently active device. Auto mode adds an anti-thrash hold time and an idle timeout back to a default pattern.

---
 rtl/device_hub_pkg.sv | 4 +
 rtl/activity_detector.sv | 14 +
 rtl/device_hub.sv | 116 +++++++++++
 3 files changed

// File: rtl/device_hub_pkg.sv
// device_hub_pkg: shared state type for the device hub
package device_hub_pkg;
  typedef enum logic [1:0] {S_MANUAL, S_IDLE, S_HOLD, S_TRACK} hub_state_t;
endpackage

// File: rtl/activity_detector.sv
// activity_detector: remembers a channel's last sampled payload and flags changes
module activity_detector #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data,
  input  logic         valid,
  output logic         act
);
  logic [W-1:0] last;
  always_ff @(posedge clk) last <= rst ? '0 : valid ? data : last;
  assign act = valid && (data != last);
endmodule

// File: rtl/device_hub.sv
// device_hub: routes one of N_CH device payloads to the display, manually or by latest activity
module device_hub
  import device_hub_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int W           = 8,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int IDLE_CYCLES = 250_000_000,
  parameter int SELW        = $clog2(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_CH*W-1:0] i_data,
  input  logic [N_CH-1:0]   i_valid,
  input  logic              i_mode,
  input  logic [SELW-1:0]   i_sel,
  input  logic [W-1:0]      i_default,
  output logic [W-1:0]      o_data,
  output logic [SELW-1:0]   o_active_ch,
  output logic              o_idle,
  output logic              o_switch
);
  localparam int HW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int IW = IDLE_CYCLES > 0 ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES > 0 ? IDLE_CYCLES - 1 : 0);
  localparam hub_state_t AFTER_SWITCH = HOLD_CYCLES == 0 ? S_TRACK : S_HOLD;
  hub_state_t state, state_nxt;
  logic [N_CH-1:0] act;
  logic [W-1:0] chan [N_CH];
  logic [SELW-1:0] low, ch_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt, idle_inc;
  logic [W-1:0] data_nxt;
  logic idle_o_nxt, switch_nxt, any_act, cur_act, sel_ok, hold_done, idle_done;
  for (genvar k = 0; k < N_CH; k++) begin : g_det
    assign chan[k] = i_data[k*W +: W];
    activity_detector #(.W(W)) u_det (
      .clk  (i_clk),
      .rst  (i_reset),
      .data (chan[k]),
      .valid(i_valid[k]),
      .act  (act[k])
    );
  end
  always_comb begin
    low = '0;
    for (int k = N_CH - 1; k >= 0; k--) if (act[k]) low = SELW'(k);
  end
  assign any_act   = |act;
  assign cur_act   = act[o_active_ch];
  assign sel_ok    = int'(i_sel) < N_CH;
  assign hold_done = hold_cnt == HOLD_LAST;
  assign idle_done = IDLE_CYCLES != 0 && idle_cnt == IDLE_LAST && !cur_act;
  assign idle_inc  = cur_act ? '0 : idle_cnt == IDLE_LAST ? idle_cnt : idle_cnt + 1'b1;
  always_comb begin
    state_nxt  = state;
    ch_nxt     = o_active_ch;
    hold_nxt   = '0;
    idle_nxt   = '0;
    idle_o_nxt = 1'b1;
    switch_nxt = 1'b0;
    if (!i_mode) begin
      state_nxt  = S_MANUAL;
      ch_nxt     = sel_ok ? i_sel : o_active_ch;
      idle_o_nxt = !sel_ok;
    end else begin
      case (state)
        S_MANUAL: state_nxt = S_IDLE;
        S_IDLE: if (any_act) begin
          state_nxt  = AFTER_SWITCH;
          ch_nxt     = low;
          idle_o_nxt = 1'b0;
          switch_nxt = 1'b1;
        end
        S_HOLD: if (idle_done) state_nxt = S_IDLE;
        else begin
          idle_o_nxt = 1'b0;
          idle_nxt   = idle_inc;
          hold_nxt   = hold_cnt + 1'b1;
          state_nxt  = hold_done ? S_TRACK : S_HOLD;
        end
        S_TRACK: if (idle_done) state_nxt = S_IDLE;
        else begin
          idle_o_nxt = 1'b0;
          if (!cur_act && any_act) begin
            ch_nxt     = low;
            switch_nxt = 1'b1;
            state_nxt  = AFTER_SWITCH;
          end else idle_nxt = idle_inc;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    data_nxt = idle_o_nxt ? i_default : chan[ch_nxt];
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      idle_cnt    <= '0;
      o_data      <= '0;
      o_active_ch <= '0;
      o_idle      <= 1'b1;
      o_switch    <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      idle_cnt    <= idle_nxt;
      o_data      <= data_nxt;
      o_active_ch <= ch_nxt;
      o_idle      <= idle_o_nxt;
      o_switch    <= switch_nxt;
    end
  end
endmodule
